// File: rtl/buzz_pattern_if.sv
// rtl/buzz_pattern_if.sv - control and output bundle for the buzzer pattern driver
interface buzz_pattern_if #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 24
);
  logic              s1;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  half_period_a;
  logic [CNT_W-1:0]  half_period_b;
  logic [GATE_W-1:0] gate_len;
  logic              buzz_driver;
  logic              active;

  modport master (
    output s1, mode, half_period_a, half_period_b, gate_len,
    input  buzz_driver, active
  );

  modport slave (
    input  s1, mode, half_period_a, half_period_b, gate_len,
    output buzz_driver, active
  );
endinterface

// File: rtl/buzz_pattern.sv
// rtl/buzz_pattern.sv - piezo buzzer driver: continuous, beep, two-tone and one-shot patterns
module buzz_pattern #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 24
) (
  input logic         clk,
  input logic         reset,
  buzz_pattern_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;

  state_t            state, state_n;
  logic              sync1, sync2, prev;
  logic              press;
  logic [1:0]        mode_q, mode_n;
  logic [CNT_W-1:0]  tcnt, tcnt_n, half_sel;
  logic [GATE_W-1:0] gcnt, gcnt_n, gate_last;
  logic              phase, phase_n, drv, drv_n;
  logic              gate_event, audible;

  // Button idles high, so the chain resets to 1 to avoid a phantom press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= bus.s1;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= 2'd0;
      tcnt   <= '0;
      gcnt   <= '0;
      phase  <= 1'b0;
      drv    <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      tcnt   <= tcnt_n;
      gcnt   <= gcnt_n;
      phase  <= phase_n;
      drv    <= drv_n;
    end
  end

  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    tcnt_n     = tcnt;
    gcnt_n     = gcnt;
    phase_n    = phase;
    drv_n      = drv;
    half_sel   = (phase && mode_q == 2'd2) ? bus.half_period_b : bus.half_period_a;
    gate_last  = (bus.gate_len == '0) ? '0 : bus.gate_len - GATE_W'(1);
    gate_event = (state == ST_PLAY) && (mode_q != 2'd0) && (gcnt >= gate_last);
    audible    = !(mode_q == 2'd1 && phase);

    case (state)
      ST_IDLE: begin
        tcnt_n  = '0;
        gcnt_n  = '0;
        phase_n = 1'b0;
        drv_n   = 1'b0;
        if (press) begin
          state_n = ST_PLAY;
          mode_n  = bus.mode;
        end
      end
      ST_PLAY: begin
        // A one-shot expiry and a stop press both land in idle, so one press is consumed.
        if (press || (gate_event && mode_q == 2'd3)) begin
          state_n = ST_IDLE;
          tcnt_n  = '0;
          gcnt_n  = '0;
          phase_n = 1'b0;
          drv_n   = 1'b0;
        end else begin
          if (mode_q == 2'd0) begin
            gcnt_n  = '0;
            phase_n = 1'b0;
          end else if (gate_event) begin
            gcnt_n = '0;
          end else begin
            gcnt_n = gcnt + GATE_W'(1);
          end

          if (gate_event) begin
            phase_n = ~phase;
            tcnt_n  = '0;
            drv_n   = 1'b0;
          end else if (!audible || half_sel == '0) begin
            tcnt_n = '0;
            drv_n  = 1'b0;
          end else if (tcnt >= half_sel - CNT_W'(1)) begin
            tcnt_n = '0;
            drv_n  = ~drv;
          end else begin
            tcnt_n = tcnt + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.buzz_driver = drv;
  assign bus.active      = (state == ST_PLAY);
endmodule

// File: tb/tb_buzz_pattern.sv
// tb/tb_buzz_pattern.sv - scoreboard bench for buzz_pattern output transitions
module tb_buzz_pattern;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;
  exp_t exp_q[$];

  buzz_pattern_if #(.CNT_W(16), .GATE_W(24)) bus ();
  buzz_pattern #(.CNT_W(16), .GATE_W(24)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every change of {active, buzz_driver} must match the next queued transition.
  logic [1:0] last_val = 2'b00;
  always @(negedge clk) begin
    logic [1:0] cur;
    exp_t e;
    cur = {bus.active, bus.buzz_driver};
    if (cur != last_val) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL seq_unexpected: cycle %0d value %b, expected no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val != cur) begin
          fails++;
          $display("FAIL seq: cycle %0d value %b, expected cycle %0d value %b", cyc, cur, e.cyc, e.val);
        end
      end
    end
    last_val = cur;
  end

  task automatic push(input int c, input logic a, input logic d);
    exp_t e;
    e.cyc = c;
    e.val = {a, d};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // Called at a negedge; returns the edge after which the press takes effect.
  task automatic start_press(output int e);
    bus.s1 = 1'b0;
    e = cyc + 3;
  endtask

  task automatic release_btn();
    repeat (3) @(negedge clk);
    bus.s1 = 1'b1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int e, e2, n, h;
    logic lastv;

    reset = 1'b1;
    bus.s1 = 1'b1;
    bus.mode = 2'd0;
    bus.half_period_a = '0;
    bus.half_period_b = '0;
    bus.gate_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_active", bus.active, 1'b0);
    chk("reset_driver", bus.buzz_driver, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_active", bus.active, 1'b0);

    // Continuous tone; mode change mid-play must be ignored; stop while driver high.
    bus.mode = 2'd0;
    bus.half_period_a = 16'd300;
    bus.gate_len = 24'd5;
    start_press(e);
    push(e, 1, 0); push(e + 300, 1, 1); push(e + 600, 1, 0); push(e + 900, 1, 1);
    release_btn();
    bus.mode = 2'd3;
    wait_cyc(e + 950);
    start_press(e2);
    push(e2, 0, 0);
    release_btn();
    wait_cyc(e2 + 20);

    // Beep mode, then asynchronous reset mid-beep.
    bus.mode = 2'd1;
    bus.half_period_a = 16'd4;
    bus.gate_len = 24'd32;
    start_press(e);
    push(e, 1, 0);
    for (int j = 0; j < 2; j++)
      for (int m = 1; m <= 8; m++) push(e + 64 * j + 4 * m, 1, (m % 2) == 1);
    for (int m = 1; m <= 3; m++) push(e + 128 + 4 * m, 1, (m % 2) == 1);
    release_btn();
    wait_cyc(e + 142);
    #1 reset = 1'b1;
    push(cyc + 1, 0, 0);
    #1;
    chk("async_reset_active", bus.active, 1'b0);
    chk("async_reset_driver", bus.buzz_driver, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_reset_idle", bus.active, 1'b0);

    // Two-tone alternation, stop mid-window.
    bus.mode = 2'd2;
    bus.half_period_a = 16'd3;
    bus.half_period_b = 16'd5;
    bus.gate_len = 24'd30;
    start_press(e);
    push(e, 1, 0);
    for (int j = 0; j < 4; j++) begin
      h = (j % 2 == 1) ? 5 : 3;
      lastv = 1'b0;
      for (int m = 1; h * m < 30; m++) begin
        push(e + 30 * j + h * m, 1, (m % 2) == 1);
        lastv = (m % 2) == 1;
      end
      if (lastv) push(e + 30 * j + 30, 1, 0);
    end
    push(e + 123, 1, 1);
    release_btn();
    wait_cyc(e + 121);
    start_press(e2);
    push(e2, 0, 0);
    release_btn();
    wait_cyc(e2 + 10);

    // One-shot: full burst, abort at cycle 10, press coinciding with expiry.
    bus.mode = 2'd3;
    bus.half_period_a = 16'd2;
    bus.gate_len = 24'd20;
    start_press(e);
    push(e, 1, 0);
    for (int m = 1; m <= 9; m++) push(e + 2 * m, 1, (m % 2) == 1);
    push(e + 20, 0, 0);
    release_btn();
    wait_cyc(e + 30);
    chk("oneshot_done", bus.active, 1'b0);

    start_press(e);
    push(e, 1, 0);
    for (int m = 1; m <= 4; m++) push(e + 2 * m, 1, (m % 2) == 1);
    release_btn();
    wait_cyc(e + 7);
    start_press(e2);
    push(e2, 0, 0);
    release_btn();
    wait_cyc(e2 + 10);

    start_press(e);
    push(e, 1, 0);
    for (int m = 1; m <= 9; m++) push(e + 2 * m, 1, (m % 2) == 1);
    release_btn();
    wait_cyc(e + 17);
    start_press(e2);
    push(e + 20, 0, 0);
    release_btn();
    wait_cyc(e + 60);
    chk("coincident_no_restart", bus.active, 1'b0);

    // Muted tone, then pitch set mid-run.
    bus.mode = 2'd0;
    bus.half_period_a = 16'd0;
    start_press(e);
    push(e, 1, 0);
    release_btn();
    wait_cyc(e + 20);
    chk("mute_driver", bus.buzz_driver, 1'b0);
    n = cyc;
    bus.half_period_a = 16'd2;
    push(n + 2, 1, 1); push(n + 4, 1, 0); push(n + 6, 1, 1); push(n + 8, 1, 0);
    wait_cyc(n + 7);
    start_press(e2);
    push(e2, 0, 0);
    release_btn();
    wait_cyc(e2 + 5);

    // Zero gate length in beep mode: phase flips every cycle, driver never toggles.
    bus.mode = 2'd1;
    bus.half_period_a = 16'd2;
    bus.gate_len = 24'd0;
    start_press(e);
    push(e, 1, 0);
    release_btn();
    wait_cyc(e + 30);
    start_press(e2);
    push(e2, 0, 0);
    release_btn();
    wait_cyc(e2 + 5);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL seq_drain: %0d transitions outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/buzz_pattern.md
# buzz_pattern

Parametrised piezo-buzzer driver and successor to the fixed 1.25 kHz toggle buzzer. A falling edge on the push-button input starts or stops playback. Playback runs in one of four modes: continuous tone, gated beeping, two-tone alternation, or a single-shot burst. Tone pitch and gate length are run-time inputs, so one instance covers every board alarm and indicator sound.

## Interface
Parameters:
- CNT_W, 16: width of half-period inputs and the tone counter.
- GATE_W, 24: width of the gate-length input and the gate counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s1  in  1  raw push-button. Asynchronous to clk. Pressed = low.
- mode  in  2  playback mode: 0 continuous, 1 beep, 2 two-tone, 3 one-shot.
- half_period_a  in  CNT_W  tone A half-period, in clk cycles. 0 = mute.
- half_period_b  in  CNT_W  tone B half-period, in clk cycles. 0 = mute.
- gate_len  in  GATE_W  gate phase length, in clk cycles. 0 is treated as 1.
- buzz_driver  out  1  registered square-wave output to the buzzer transistor.
- active  out  1  high while playback is enabled.

## Operation
Reset (asynchronous):
- All registers clear: sync chain to 1, enable 0, tone counter 0, gate counter 0, phase 0, buzz_driver 0.
- active = 0 and buzz_driver = 0 while reset is asserted and after it is released.

Button:
- s1 passes through a 2-flop synchroniser (sync1, sync2) plus a history flop prev.
- press = prev & ~sync2, a single-cycle falling-edge strobe.
- No debounce; the board supplies RC filtering.

Start/stop:
- press while idle: enable <= 1; latch mode into mode_q; clear tone counter, gate counter, phase and driver.
- press while enabled (any mode, including a mode-3 burst in progress): enable <= 0; driver <= 0; counters cleared.
- mode changes during playback are ignored until the next start.

Tone generator (runs while enabled and the tone is audible):
- Selected half-period H = half_period_a when phase = 0 or mode_q ∈ {0, 1, 3}; otherwise half_period_b.
- If H = 0: driver held 0 and tone counter held 0.
- Else if tcnt == H−1: tcnt <= 0 and driver <= ~driver. Otherwise tcnt <= tcnt+1.
- H is re-read every cycle, so a pitch change takes effect within one half-cycle. If tcnt ≥ H−1 after a decrease, the toggle occurs that cycle.
- Duty is 50%; full period is 2·H cycles.

Gate generator (mode_q ≠ 0):
- Effective length G = max(gate_len, 1).
- gcnt counts 0..G−1. At gcnt == G−1: gcnt <= 0 and the phase event fires.
- Mode 1: phase toggles. phase 0 = tone audible, phase 1 = silent (driver 0, tcnt 0).
- Mode 2: phase toggles. Selects tone A (0) or tone B (1). On each toggle: tcnt <= 0, driver <= 0.
- Mode 3: on the event, enable <= 0 and driver <= 0. Burst length = G cycles.
- Mode 0: gcnt and phase held at 0.

Outputs:
- active = enable.
- Whenever enable = 0, buzz_driver = 0.

## Timing
- s1 low first sampled at edge k. Then sync2 = 0 after k+1, press is true during cycle k+1..k+2, and enable/active rise after edge k+2. Latency from press to active is 3 edges.
- Enable rises at edge E. buzz_driver first rises after edge E+H, then toggles every H edges.
- Mode 1/2 phase events occur after edges E+G, E+2G, …
- Mode 3: active falls after edge E+G, and buzz_driver is 0 from the same edge.
- Stop press: active and buzz_driver are 0 after the edge on which press is seen, regardless of driver phase.
- A press on the same edge as a mode-3 burst expiry: the burst expiry wins, so enable = 0. The press is consumed and does not restart playback.
- reset mid-playback: outputs 0 immediately (asynchronous). After release, the block is idle and needs a new press.

## Test plan
- Reset, then mode=0, half_a=20000, one press → active high 3 edges after s1 falls. buzz_driver low for 20000 cycles, then period 40000 with 20000 high. Second press → driver 0 within 1 edge.
- mode=1, half_a=4, gate_len=32, press → 32 cycles of period-8 square wave, then 32 cycles low, repeating. First high begins 4 cycles after active.
- mode=2, half_a=3, half_b=5, gate_len=30 → alternate 30-cycle windows of period 6 and period 10. Driver is low at the start of each window.
- mode=3, half_a=2, gate_len=20, press → active high exactly 20 cycles, 5 full periods, then active = 0 and driver = 0. Repeat with a press at cycle 10 → abort at cycle 10.
- half_a=0 in mode 0 → active = 1 and driver stays 0. Set half_a=2 mid-run → toggling starts within 2 cycles. gate_len=0 in mode 1 → phase toggles every cycle, driver never toggles.
- Assert reset for 1 cycle mid-beep (mode 1) → driver and active 0 asynchronously. Stay idle after release until a new press.
